// File: rtl/flash_burst_reader.sv
// Avalon-MM burst read master: streams a flash word range into a first-word-fall-through FIFO.
// Build option FLASH_READER_LOOP_EN: replay the latched range until abort (done never pulses).
module flash_burst_reader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 23,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       reader_clk,
  input  logic                       reader_rst_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          start_addr,
  input  logic [ADDR_W-1:0]          word_count,
  input  logic                       abort,
  output logic                       flash_mem_read,
  output logic [ADDR_W-1:0]          flash_mem_address,
  output logic [$clog2(BURST_LEN):0] flash_mem_burstcount,
  input  logic                       flash_mem_waitrequest,
  input  logic                       flash_mem_readdatavalid,
  input  logic [DATA_W-1:0]          flash_mem_readdata,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);
  localparam int BC_W  = $clog2(BURST_LEN) + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_ABORT} state_t;

  state_t             state_q, state_d;
  logic               read_q, read_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  rem_q, rem_d;
  logic [BC_W-1:0]    blen_q, blen_d;
  logic [BC_W-1:0]    beats_q, beats_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
`ifdef FLASH_READER_LOOP_EN
  logic [ADDR_W-1:0]  loop_addr_q, loop_addr_d;
  logic [ADDR_W-1:0]  loop_cnt_q, loop_cnt_d;
`endif

  logic               push_c, pop_c, flush_c, last_beat_c;
  logic [ADDR_W-1:0]  blen_c;
  logic [CNT_W-1:0]   free_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid            = (count_q != '0);
  assign out_data             = out_valid ? mem_q[rd_ptr_q] : '0;
  assign flash_mem_read       = read_q;
  assign flash_mem_address    = addr_q;
  assign flash_mem_burstcount = blen_q;
  assign busy                 = busy_q;
  assign done                 = done_q;

  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    blen_d  = blen_q;
    beats_d = beats_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef FLASH_READER_LOOP_EN
    loop_addr_d = loop_addr_q;
    loop_cnt_d  = loop_cnt_q;
`endif
    push_c      = 1'b0;
    flush_c     = 1'b0;
    pop_c       = out_valid && out_ready;
    blen_c      = (rem_q < ADDR_W'(BURST_LEN)) ? rem_q : ADDR_W'(BURST_LEN);
    // In REQ nothing is outstanding, so the credit is simply the free FIFO space.
    free_c      = CNT_W'(FIFO_DEPTH) - count_q;
    last_beat_c = flash_mem_readdatavalid && ((beats_q + BC_W'(1)) == blen_q);

    case (state_q)
      S_IDLE: begin
        if (!abort && start) begin
`ifdef FLASH_READER_LOOP_EN
          loop_addr_d = start_addr;
          loop_cnt_d  = word_count;
`endif
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = start_addr;
            rem_d   = word_count;
            busy_d  = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (read_q && !flash_mem_waitrequest) begin
          read_d  = 1'b0;
          addr_d  = addr_q + ADDR_W'(blen_q);
          rem_d   = rem_q - ADDR_W'(blen_q);
          beats_d = '0;
          if (abort) begin
            flush_c = 1'b1;
            state_d = S_ABORT;
          end else begin
            state_d = S_WAIT;
          end
        end else if (abort) begin
          read_d  = 1'b0;
          flush_c = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (!read_q && (free_c >= CNT_W'(blen_c))) begin
          read_d = 1'b1;
          blen_d = BC_W'(blen_c);
        end
      end
      S_WAIT: begin
        if (flash_mem_readdatavalid) begin
          beats_d = beats_q + BC_W'(1);
          push_c  = !abort;
        end
        if (abort) begin
          flush_c = 1'b1;
          if (last_beat_c) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_ABORT;
          end
        end else if (last_beat_c) begin
          if (rem_q != '0) begin
            state_d = S_REQ;
          end else begin
`ifdef FLASH_READER_LOOP_EN
            addr_d  = loop_addr_q;
            rem_d   = loop_cnt_q;
            state_d = S_REQ;
`else
            state_d = S_DRAIN;
`endif
          end
        end
      end
      S_ABORT: begin
        // The in-flight burst cannot be cancelled; swallow its remaining beats.
        flush_c = 1'b1;
        if (flash_mem_readdatavalid) beats_d = beats_q + BC_W'(1);
        if (last_beat_c) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          flush_c = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (count_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge reader_clk or negedge reader_rst_n) begin
    if (!reader_rst_n) begin
      state_q  <= S_IDLE;
      read_q   <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      blen_q   <= '0;
      beats_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef FLASH_READER_LOOP_EN
      loop_addr_q <= '0;
      loop_cnt_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      blen_q   <= blen_d;
      beats_q  <= beats_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef FLASH_READER_LOOP_EN
      loop_addr_q <= loop_addr_d;
      loop_cnt_q  <= loop_cnt_d;
`endif
    end
  end

  always_ff @(posedge reader_clk) begin
    if (push_c) mem_q[wr_ptr_q] <= flash_mem_readdata;
  end

  // The credit check in REQ makes a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge reader_clk) disable iff (!reader_rst_n)
    !(push_c && !pop_c && (count_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_flash_burst_reader.sv
// Bench for flash_burst_reader: a table of transfers and hand-written corner sequences,
// with a behavioural Avalon burst slave and a data/burst scoreboard.
`timescale 1ns/1ps
module tb_flash_burst_reader;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 23;
  localparam int BURST_LEN = 8;
  localparam int BC_W      = 4;

  logic              clk, rst_n, start, abort, waitreq, rdv, rdy;
  logic [ADDR_W-1:0] saddr, wcnt;
  logic [DATA_W-1:0] rdata;
  logic              rd, ov, busy, done;
  logic [ADDR_W-1:0] addr;
  logic [BC_W-1:0]   bc;
  logic [DATA_W-1:0] od;

  typedef struct { logic [ADDR_W-1:0] a; logic [BC_W-1:0] n; } burst_t;
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] wc;
    int stall_idx;
    int stall_len;
    int ready_mode;
    int gap_mode;
    int exp_bursts;
  } vec_t;

  logic [DATA_W-1:0] exp_data[$];
  burst_t            exp_burst[$];
  logic [ADDR_W-1:0] beat_q[$];
  vec_t              vt[7];

  int n_cmp = 0, n_fail = 0;
  int done_cnt, bursts_acc, beats_sent, stalls_seen, words_out, burst_idx;
  int stall_idx = -1, stall_len = 0, ready_mode = 0, gap_mode = 0;
  bit hold_ready = 0, abort_test = 0, rd_seen = 0;

  flash_burst_reader dut (
    .reader_clk(clk), .reader_rst_n(rst_n), .start(start), .start_addr(saddr),
    .word_count(wcnt), .abort(abort), .flash_mem_read(rd), .flash_mem_address(addr),
    .flash_mem_burstcount(bc), .flash_mem_waitrequest(waitreq),
    .flash_mem_readdatavalid(rdv), .flash_mem_readdata(rdata),
    .out_data(od), .out_valid(ov), .out_ready(rdy), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
    return {9'h15A, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] wc);
    logic [ADDR_W-1:0] p, rem, b;
    for (int i = 0; i < int'(wc); i++) exp_data.push_back(data_of(a + ADDR_W'(i)));
    p = a;
    rem = wc;
    while (rem != '0) begin
      b = (rem < ADDR_W'(BURST_LEN)) ? rem : ADDR_W'(BURST_LEN);
      exp_burst.push_back('{p, BC_W'(b)});
      p = p + b;
      rem = rem - b;
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] wc);
    done_cnt = 0; bursts_acc = 0; beats_sent = 0; stalls_seen = 0; words_out = 0; burst_idx = 0;
    @(negedge clk);
    saddr = a; wcnt = wc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles && done_cnt == 0; i++) @(negedge clk);
    chk("done_seen", done_cnt, 1);
    chk("words_left_at_done", exp_data.size(), 0);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after_done", busy, 0);
    chk("out_valid_after_done", ov, 0);
    chk("bursts_left", exp_burst.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    stall_idx = v.stall_idx; stall_len = v.stall_len;
    ready_mode = v.ready_mode; gap_mode = v.gap_mode;
    push_exp(v.addr, v.wc);
    pulse_start(v.addr, v.wc);
    chk("busy_after_start", busy, 1);
    wait_done(3000);
    chk("burst_count", bursts_acc, v.exp_bursts);
    chk("stall_cycles", stalls_seen, (v.stall_idx < v.exp_bursts) ? v.stall_len : 0);
  endtask

  // Avalon burst slave: optional stall on one burst, beats with configurable gaps.
  initial begin : slave
    bit in_req;
    int stall_cnt, gap_cnt;
    logic [ADDR_W-1:0] req_addr;
    logic [BC_W-1:0] req_bc;
    burst_t eb;
    in_req = 0; stall_cnt = 0; gap_cnt = 0; req_addr = '0; req_bc = '0;
    waitreq = 1'b0; rdv = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      if (beat_q.size() != 0 && gap_cnt == 0) begin
        rdv = 1'b1;
        rdata = data_of(beat_q.pop_front());
        beats_sent++;
        gap_cnt = (gap_mode == 1) ? int'($urandom_range(0, 2)) : ((gap_mode == 2) ? 2 : 0);
      end else begin
        rdv = 1'b0;
        rdata = '0;
        if (gap_cnt > 0) gap_cnt--;
      end
      if (rd) begin
        rd_seen = 1;
        if (!in_req) begin
          in_req = 1;
          req_addr = addr;
          req_bc = bc;
          stall_cnt = (burst_idx == stall_idx) ? stall_len : 0;
        end else begin
          chk("req_addr_stable", addr, req_addr);
          chk("req_bc_stable", bc, req_bc);
        end
        if (stall_cnt > 0) begin
          waitreq = 1'b1;
          stall_cnt--;
          stalls_seen++;
        end else begin
          waitreq = 1'b0;
          in_req = 0;
          burst_idx++;
          bursts_acc++;
          if (exp_burst.size() == 0) begin
            chk("burst_extra", exp_burst.size(), 1);
          end else begin
            eb = exp_burst.pop_front();
            chk("burst_addr", addr, eb.a);
            chk("burst_len", bc, eb.n);
          end
          for (int j = 0; j < int'(bc); j++) beat_q.push_back(addr + ADDR_W'(j));
        end
      end else begin
        if (in_req && !abort_test) chk("req_held", rd, 1);
        in_req = 0;
        waitreq = 1'b0;
      end
    end
  end

  // Downstream consumer and scoreboard check of the output stream.
  initial begin : consumer
    rdy = 1'b0;
    forever begin
      @(negedge clk);
      rdy = hold_ready ? 1'b0 : ((ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (done) done_cnt++;
      if (ov && rdy) begin
        if (exp_data.size() == 0) chk("data_extra", exp_data.size(), 1);
        else chk("out_data", od, exp_data.pop_front());
        words_out++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; saddr = '0; wcnt = '0;
    vt[0] = '{23'h000100, 23'd20, -1, 0, 0, 0, 3};
    vt[1] = '{23'h000100, 23'd20,  1, 5, 0, 0, 3};
    vt[2] = '{23'h7FFFFC, 23'd12, -1, 0, 1, 1, 2};
    vt[3] = '{23'h000000, 23'd1,   0, 3, 1, 0, 1};
    vt[4] = '{23'h000200, 23'd8,  -1, 0, 1, 1, 1};
    vt[5] = '{23'h000300, 23'd17,  2, 2, 0, 1, 3};
    vt[6] = '{23'h7FFFF9, 23'd9,  -1, 0, 1, 2, 2};

    repeat (3) @(negedge clk);
    chk("rst_read", rd, 0);
    chk("rst_address", addr, 0);
    chk("rst_burstcount", bc, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_out_data", od, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef FLASH_READER_LOOP_EN
    ready_mode = 0; gap_mode = 0;
    for (int k = 0; k < 6; k++) push_exp(23'h7FFFFE, 23'd4);
    pulse_start(23'h7FFFFE, 23'd4);
    for (int i = 0; i < 600 && words_out < 12; i++) @(negedge clk);
    chk("loop_words", words_out >= 12, 1);
    chk("loop_busy", busy, 1);
    chk("loop_no_done", done_cnt, 0);
    abort_test = 1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 100 && beat_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("loop_abort_busy", busy, 0);
    chk("loop_abort_out_valid", ov, 0);
    chk("loop_abort_done", done_cnt, 0);
    exp_data.delete();
    exp_burst.delete();
    abort_test = 0;
`else
    for (int k = 0; k < 7; k++) run_vec(vt[k]);

    // Backpressure: a stalled consumer limits the reader to two bursts.
    stall_idx = -1; stall_len = 0; ready_mode = 0; gap_mode = 0; hold_ready = 1;
    push_exp(23'h000400, 23'd40);
    pulse_start(23'h000400, 23'd40);
    repeat (60) @(negedge clk);
    chk("bp_bursts", bursts_acc, 2);
    chk("bp_read_low", rd, 0);
    chk("bp_out_valid", ov, 1);
    hold_ready = 0;
    wait_done(3000);
    chk("bp_total_bursts", bursts_acc, 5);
    chk("bp_words", words_out, 40);

    // Abort mid-burst: remaining beats are swallowed.
    hold_ready = 1; abort_test = 1; gap_mode = 2;
    push_exp(23'h000500, 23'd8);
    pulse_start(23'h000500, 23'd8);
    for (int i = 0; i < 200 && beats_sent < 3; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_out_valid", ov, 0);
    chk("abort_busy_held", busy, 1);
    for (int i = 0; i < 200 && beat_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("abort_busy_low", busy, 0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_out_valid_end", ov, 0);
    chk("abort_beats", beats_sent, 8);
    exp_data.delete();
    hold_ready = 0; abort_test = 0; gap_mode = 0;
    run_vec(vt[0]);

    // Asynchronous reset in the middle of a burst.
    hold_ready = 1; abort_test = 1;
    push_exp(23'h000600, 23'd16);
    pulse_start(23'h000600, 23'd16);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_read", rd, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", ov, 0);
    chk("arst_burstcount", bc, 0);
    @(negedge clk);
    beat_q.delete(); exp_data.delete(); exp_burst.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    hold_ready = 0; abort_test = 0;

    // Zero-length transfer: done next cycle, no bus traffic.
    done_cnt = 0; rd_seen = 0;
    @(negedge clk);
    saddr = 23'h000700; wcnt = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_pulse", done, 0);
    repeat (3) @(negedge clk);
    chk("zero_no_read", rd_seen, 0);
    chk("zero_done_count", done_cnt, 1);

    // Abort and start together: abort wins.
    rd_seen = 0;
    @(negedge clk);
    saddr = 23'h000800; wcnt = 23'd5; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_wins_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("abort_wins_no_read", rd_seen, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
